// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, redirects on
// decode's bne/j decision from the held IF/ID word, and squashes the wrong-path fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        pcSrc,
    input  logic        jumpSrc,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    output logic [31:0] pc,
    output logic [31:0] ifIdInstr,
    output logic [31:0] ifIdPcPlus4,
    output logic        ifIdValid,
    output logic        redirect
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcPlus4_q, pcPlus4_d;
    logic        valid_q, valid_d;

    logic [31:0] pcPlus4;
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;

    assign pcPlus4      = pc_q + 32'd4;
    assign branchTarget = pcPlus4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign jumpTarget   = {pcPlus4_q[31:28], instr_q[25:0], 2'b00};

    // A bubble in IF/ID can never redirect, whatever decode drives.
    assign redirect = ~stall & valid_q & (pcSrc | jumpSrc);

    always_comb begin
        pc_d      = pcPlus4;
        instr_d   = imemData;
        pcPlus4_d = pcPlus4;
        valid_d   = 1'b1;
        if (stall) begin
            pc_d      = pc_q;
            instr_d   = instr_q;
            pcPlus4_d = pcPlus4_q;
            valid_d   = valid_q;
        end else if (redirect) begin
            pc_d      = jumpSrc ? jumpTarget : branchTarget;
            instr_d   = NOP_WORD;
            pcPlus4_d = 32'd0;
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= NOP_WORD;
            pcPlus4_q <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcPlus4_q <= pcPlus4_d;
            valid_q   <= valid_d;
        end
    end

    assign pc          = pc_q;
    assign imemAddr    = pc_q;
    assign ifIdInstr   = instr_q;
    assign ifIdPcPlus4 = pcPlus4_q;
    assign ifIdValid   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a combinational instruction
// memory model; each phase reloads memory and resets before replaying its vectors.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        pcSrc;
    logic        jumpSrc;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic [31:0] pc;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPcPlus4;
    logic        ifIdValid;
    logic        redirect;

    int checksTotal = 0;
    int checksPassed = 0;

    logic [31:0] mem [0:63];

    typedef struct {
        int          phase;
        logic        stall;
        logic        pcSrc;
        logic        jumpSrc;
        logic        expRedirect;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic [31:0] expPcPlus4;
        logic        expValid;
    } vec_t;

    vec_t vecs[$];

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .pcSrc      (pcSrc),
        .jumpSrc    (jumpSrc),
        .imemAddr   (imemAddr),
        .imemData   (imemData),
        .pc         (pc),
        .ifIdInstr  (ifIdInstr),
        .ifIdPcPlus4(ifIdPcPlus4),
        .ifIdValid  (ifIdValid),
        .redirect   (redirect)
    );

    always #5 clk = ~clk;

    // Low 256 bytes come from the table; anything above reads back address+1.
    assign imemData = (imemAddr < 32'h100) ? mem[imemAddr[7:2]] : imemAddr + 32'd1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksTotal++;
        if (act === exp) checksPassed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic setupMem(input int phase);
        for (int i = 0; i < 64; i++) mem[i] = i * 4 + 1;
        case (phase)
            1: mem[1] = 32'h1420_0003;
            2, 5, 6: mem[3] = 32'h0800_0040;
            3: mem[7] = 32'h1420_FFFE;
            4: mem[1] = 32'h1420_FFFD;
            default: ;
        endcase
    endtask

    task automatic resetDut();
        rst_n   = 1'b0;
        stall   = 1'b0;
        pcSrc   = 1'b0;
        jumpSrc = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset pc", pc, 32'h0);
        checkOutput("reset imemAddr", imemAddr, 32'h0);
        checkOutput("reset ifIdInstr", ifIdInstr, 32'h0);
        checkOutput("reset ifIdPcPlus4", ifIdPcPlus4, 32'h0);
        checkOutput("reset ifIdValid", {31'd0, ifIdValid}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        stall   = v.stall;
        pcSrc   = v.pcSrc;
        jumpSrc = v.jumpSrc;
        #3;
        checkOutput($sformatf("v%0d redirect", idx), {31'd0, redirect}, {31'd0, v.expRedirect});
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d pc", idx), pc, v.expPc);
        checkOutput($sformatf("v%0d imemAddr", idx), imemAddr, v.expPc);
        checkOutput($sformatf("v%0d ifIdInstr", idx), ifIdInstr, v.expInstr);
        checkOutput($sformatf("v%0d ifIdPcPlus4", idx), ifIdPcPlus4, v.expPcPlus4);
        checkOutput($sformatf("v%0d ifIdValid", idx), {31'd0, ifIdValid}, {31'd0, v.expValid});
    endtask

    function automatic void addVec(input int ph, input logic s, input logic b, input logic j,
                                   input logic r, input logic [31:0] p, input logic [31:0] ins,
                                   input logic [31:0] p4, input logic v);
        vec_t t;
        t.phase = ph; t.stall = s; t.pcSrc = b; t.jumpSrc = j; t.expRedirect = r;
        t.expPc = p; t.expInstr = ins; t.expPcPlus4 = p4; t.expValid = v;
        vecs.push_back(t);
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Phase 0: sequential fetch, bubble ignores decode, stall holds.
        addVec(0, 0, 1, 1, 0, 32'h04, 32'h01, 32'h04, 1);
        addVec(0, 0, 0, 0, 0, 32'h08, 32'h05, 32'h08, 1);
        addVec(0, 0, 0, 0, 0, 32'h0C, 32'h09, 32'h0C, 1);
        addVec(0, 1, 1, 0, 0, 32'h0C, 32'h09, 32'h0C, 1);
        addVec(0, 0, 0, 0, 0, 32'h10, 32'h0D, 32'h10, 1);
        // Phase 1: bne taken forward, then pcSrc glitch during the bubble.
        addVec(1, 0, 0, 0, 0, 32'h04, 32'h01, 32'h04, 1);
        addVec(1, 0, 0, 0, 0, 32'h08, 32'h1420_0003, 32'h08, 1);
        addVec(1, 0, 1, 0, 1, 32'h14, 32'h00, 32'h00, 0);
        addVec(1, 0, 1, 0, 0, 32'h18, 32'h15, 32'h18, 1);
        addVec(1, 0, 0, 0, 0, 32'h1C, 32'h19, 32'h1C, 1);
        // Phase 2: jump with pcSrc also forced, then 3-cycle stall over a pending bne.
        addVec(2, 0, 0, 0, 0, 32'h04, 32'h01, 32'h04, 1);
        addVec(2, 0, 0, 0, 0, 32'h08, 32'h05, 32'h08, 1);
        addVec(2, 0, 0, 0, 0, 32'h0C, 32'h09, 32'h0C, 1);
        addVec(2, 0, 0, 0, 0, 32'h10, 32'h0800_0040, 32'h10, 1);
        addVec(2, 0, 1, 1, 1, 32'h100, 32'h00, 32'h00, 0);
        addVec(2, 0, 0, 0, 0, 32'h104, 32'h101, 32'h104, 1);
        addVec(2, 1, 1, 0, 0, 32'h104, 32'h101, 32'h104, 1);
        addVec(2, 1, 1, 0, 0, 32'h104, 32'h101, 32'h104, 1);
        addVec(2, 1, 1, 0, 0, 32'h104, 32'h101, 32'h104, 1);
        addVec(2, 0, 1, 0, 1, 32'h508, 32'h00, 32'h00, 0);
        addVec(2, 0, 0, 0, 0, 32'h50C, 32'h509, 32'h50C, 1);
        // Phase 3: backward bne with imm = -2.
        addVec(3, 0, 0, 0, 0, 32'h04, 32'h01, 32'h04, 1);
        addVec(3, 0, 0, 0, 0, 32'h08, 32'h05, 32'h08, 1);
        addVec(3, 0, 0, 0, 0, 32'h0C, 32'h09, 32'h0C, 1);
        addVec(3, 0, 0, 0, 0, 32'h10, 32'h0D, 32'h10, 1);
        addVec(3, 0, 0, 0, 0, 32'h14, 32'h11, 32'h14, 1);
        addVec(3, 0, 0, 0, 0, 32'h18, 32'h15, 32'h18, 1);
        addVec(3, 0, 0, 0, 0, 32'h1C, 32'h19, 32'h1C, 1);
        addVec(3, 0, 0, 0, 0, 32'h20, 32'h1420_FFFE, 32'h20, 1);
        addVec(3, 0, 1, 0, 1, 32'h18, 32'h00, 32'h00, 0);
        addVec(3, 0, 0, 0, 0, 32'h1C, 32'h19, 32'h1C, 1);
        // Phase 4: branch to 0xFFFF_FFFC, then PC wraps to zero.
        addVec(4, 0, 0, 0, 0, 32'h04, 32'h01, 32'h04, 1);
        addVec(4, 0, 0, 0, 0, 32'h08, 32'h1420_FFFD, 32'h08, 1);
        addVec(4, 0, 1, 0, 1, 32'hFFFF_FFFC, 32'h00, 32'h00, 0);
        addVec(4, 0, 0, 0, 0, 32'h00, 32'hFFFF_FFFD, 32'h00, 1);
        addVec(4, 0, 0, 0, 0, 32'h04, 32'h01, 32'h04, 1);
        // Phase 5: plain jump.
        addVec(5, 0, 0, 0, 0, 32'h04, 32'h01, 32'h04, 1);
        addVec(5, 0, 0, 0, 0, 32'h08, 32'h05, 32'h08, 1);
        addVec(5, 0, 0, 0, 0, 32'h0C, 32'h09, 32'h0C, 1);
        addVec(5, 0, 0, 0, 0, 32'h10, 32'h0800_0040, 32'h10, 1);
        addVec(5, 0, 0, 1, 1, 32'h100, 32'h00, 32'h00, 0);
        addVec(5, 0, 0, 0, 0, 32'h104, 32'h101, 32'h104, 1);
        // Phase 6: run up to a jump; the async reset is hand-sequenced below.
        addVec(6, 0, 0, 0, 0, 32'h04, 32'h01, 32'h04, 1);
        addVec(6, 0, 0, 0, 0, 32'h08, 32'h05, 32'h08, 1);
        addVec(6, 0, 0, 0, 0, 32'h0C, 32'h09, 32'h0C, 1);
        addVec(6, 0, 0, 0, 0, 32'h10, 32'h0800_0040, 32'h10, 1);

        for (int ph = 0; ph <= 6; ph++) begin
            setupMem(ph);
            resetDut();
            for (int i = 0; i < vecs.size(); i++)
                if (vecs[i].phase == ph) applyStimulus(vecs[i], i);
        end

        // Reset lands between edges while a jump redirect is pending.
        jumpSrc = 1'b1;
        #2;
        checkOutput("async pre redirect", {31'd0, redirect}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async pc", pc, 32'h0);
        checkOutput("async imemAddr", imemAddr, 32'h0);
        checkOutput("async ifIdInstr", ifIdInstr, 32'h0);
        checkOutput("async ifIdValid", {31'd0, ifIdValid}, 32'd0);
        checkOutput("async redirect", {31'd0, redirect}, 32'd0);
        jumpSrc = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("held reset pc", pc, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post reset pc", pc, 32'h04);
        checkOutput("post reset ifIdInstr", ifIdInstr, 32'h01);
        checkOutput("post reset ifIdValid", {31'd0, ifIdValid}, 32'd1);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
